// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction-fetch initiator for the Project2 processor. Owns the program
//   counter, presents it to a combinational instruction memory, and captures
//   the returned word into a valid/ready output register for decode. Handles
//   branch redirects from execute and back-pressure from decode.
//
//   Optional feature macro: FETCH_ALIGN_CHECK_EN
//     defined   : a redirect to a target with br_target[1:0] != 0 freezes the
//                 unit in FAULT (fetch_fault = 1) until RESET.
//     undefined : targets are used as given, FAULT is unreachable and
//                 fetch_fault is tied low.
//
//   Output handshake (ir_valid / ir_ready):
//     ir_valid is asserted when ir_inst/ir_pc/ir_pcplus hold an instruction.
//     A transfer happens in any cycle where ir_valid && ir_ready; the payload
//     is stable and ir_valid stays high while ir_valid && !ir_ready, except
//     that a redirect (or FAULT entry) withdraws the held instruction.
//     ir_valid never depends combinationally on ir_ready.
//
//   fsm_state exposes the controller state (BOOT/RUN/FAULT) for debug.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int unsigned            DBITS     = 32,
    parameter logic [DBITS-1:0]       INST_SIZE = 32'd4,
    parameter logic [DBITS-1:0]       START_PC  = 32'h40
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    output logic [DBITS-1:0]  pcOut,
    input  logic [DBITS-1:0]  instWord,
    input  logic              br_taken,
    input  logic [DBITS-1:0]  br_target,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DBITS-1:0]  ir_inst,
    output logic [DBITS-1:0]  ir_pc,
    output logic [DBITS-1:0]  ir_pcplus,
    output logic [DBITS-1:0]  fetch_count,
    output logic              fetch_fault,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DBITS-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [DBITS-1:0] inst_q, inst_d;
    logic [DBITS-1:0] irpc_q, irpc_d;
    logic [DBITS-1:0] count_q, count_d;

    logic             load;
    logic             xfer;
    logic             misaligned;

    // Decode may take a new word whenever the output register is empty or
    // is being drained this cycle.
    assign load = !valid_q || ir_ready;
    assign xfer = valid_q && ir_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned  = (br_target[1:0] != 2'b00);
    // FAULT is only left through RESET, so the sticky flag is the state itself.
    assign fetch_fault = (state_q == ST_FAULT);
`else
    assign misaligned  = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Next-state and datapath update: FAULT entry > redirect > load > hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        irpc_d  = irpc_q;
        // A transfer is counted whatever else happens to the register.
        count_d = xfer ? (count_q + {{(DBITS-1){1'b0}}, 1'b1}) : count_q;

        case (state_q)
            ST_BOOT: begin
                // One idle cycle after reset; redirects are not honoured yet.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (br_taken && misaligned) begin
                    state_d = ST_FAULT;
                    pc_d    = br_target;
                    valid_d = 1'b0;
                end else if (br_taken) begin
                    // Discard whatever is held; the target word arrives next cycle.
                    pc_d    = br_target;
                    valid_d = 1'b0;
                end else if (load) begin
                    inst_d  = instWord;
                    irpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + INST_SIZE;
                end
            end
            ST_FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= ST_BOOT;
            pc_q    <= START_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            irpc_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            irpc_q  <= irpc_d;
            count_q <= count_d;
        end
    end

    assign pcOut       = pc_q;
    assign ir_valid    = valid_q;
    assign ir_inst     = inst_q;
    assign ir_pc       = irpc_q;
    assign ir_pcplus   = irpc_q + INST_SIZE;
    assign fetch_count = count_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Table-driven bench for inst_fetch_unit. Each record gives the inputs held
//   across one rising edge and the outputs expected just after it. Memory is a
//   small combinational lookup. Build with +define+FETCH_ALIGN_CHECK_EN to
//   exercise the alignment-fault variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch_unit;

    localparam int W = 32;

    logic          CLOCK_50;
    logic          RESET;
    logic [W-1:0]  pcOut;
    logic [W-1:0]  instWord;
    logic          br_taken;
    logic [W-1:0]  br_target;
    logic          ir_valid;
    logic          ir_ready;
    logic [W-1:0]  ir_inst;
    logic [W-1:0]  ir_pc;
    logic [W-1:0]  ir_pcplus;
    logic [W-1:0]  fetch_count;
    logic          fetch_fault;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_unit dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .pcOut       (pcOut),
        .instWord    (instWord),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_inst     (ir_inst),
        .ir_pc       (ir_pc),
        .ir_pcplus   (ir_pcplus),
        .fetch_count (fetch_count),
        .fetch_fault (fetch_fault),
        .fsm_state   (fsm_state)
    );

    // clock
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // instruction memory, combinational read
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        case (a)
            32'h0000_0040: return 32'h2f00_0000;
            32'h0000_0044: return 32'h3b00_0700;
            32'h0000_0048: return 32'hc0ff_fd00;
            32'hffff_fffc: return 32'hdead_beef;
            32'h0000_0000: return 32'h0123_4567;
            default:       return a ^ 32'h5a5a_0000;
        endcase
    endfunction

    always_comb instWord = mem_word(pcOut);

    typedef struct {
        logic          rst;
        logic          ready;
        logic          br;
        logic [W-1:0]  target;
        logic          chk_ir;
        logic          e_valid;
        logic [W-1:0]  e_inst;
        logic [W-1:0]  e_irpc;
        logic [W-1:0]  e_pcout;
        logic [W-1:0]  e_count;
        logic          e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ready, input logic br,
                       input logic [W-1:0] target, input logic chk_ir,
                       input logic e_valid, input logic [W-1:0] e_inst,
                       input logic [W-1:0] e_irpc, input logic [W-1:0] e_pcout,
                       input logic [W-1:0] e_count, input logic e_fault);
        vec_t v;
        v.rst = rst; v.ready = ready; v.br = br; v.target = target;
        v.chk_ir = chk_ir; v.e_valid = e_valid; v.e_inst = e_inst;
        v.e_irpc = e_irpc; v.e_pcout = e_pcout; v.e_count = e_count;
        v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: hold inputs across one rising edge, sample 1ns after it
    task automatic step(input logic rst, input logic ready, input logic br,
                        input logic [W-1:0] target);
        RESET = rst; ir_ready = ready; br_taken = br; br_target = target;
        @(posedge CLOCK_50);
        #1;
    endtask

    localparam logic [W-1:0] I40 = 32'h2f00_0000;
    localparam logic [W-1:0] I44 = 32'h3b00_0700;
    localparam logic [W-1:0] I48 = 32'hc0ff_fd00;
    localparam logic [W-1:0] X   = 32'h0;

    initial begin
        int edges;
        RESET = 1'b1; ir_ready = 1'b1; br_taken = 1'b0; br_target = '0;

        //   rst rdy br target          chk v  inst          irpc          pcOut         cnt  flt
        // reset held two cycles, then free-run
        add(1, 1, 0, X,                 1, 0, X,            X,            32'h40,       0,   0);
        add(1, 1, 0, X,                 1, 0, X,            X,            32'h40,       0,   0);
        add(0, 1, 0, X,                 0, 0, X,            X,            32'h40,       0,   0);
        add(0, 1, 0, X,                 1, 1, I40,          32'h40,       32'h44,       0,   0);
        add(0, 1, 0, X,                 1, 1, I44,          32'h44,       32'h48,       1,   0);
        add(0, 1, 0, X,                 1, 1, I48,          32'h48,       32'h4c,       2,   0);
        // loop redirect to 0x40 while ir_pc = 0x48, twice
        add(0, 1, 1, 32'h40,            0, 0, X,            X,            32'h40,       3,   0);
        add(0, 1, 0, X,                 1, 1, I40,          32'h40,       32'h44,       3,   0);
        add(0, 1, 0, X,                 1, 1, I44,          32'h44,       32'h48,       4,   0);
        add(0, 1, 0, X,                 1, 1, I48,          32'h48,       32'h4c,       5,   0);
        add(0, 1, 1, 32'h40,            0, 0, X,            X,            32'h40,       6,   0);
        add(0, 1, 0, X,                 1, 1, I40,          32'h40,       32'h44,       6,   0);
        add(0, 1, 0, X,                 1, 1, I44,          32'h44,       32'h48,       7,   0);
        // stall three cycles on 3b000700
        add(0, 0, 0, X,                 1, 1, I44,          32'h44,       32'h48,       7,   0);
        add(0, 0, 0, X,                 1, 1, I44,          32'h44,       32'h48,       7,   0);
        add(0, 0, 0, X,                 1, 1, I44,          32'h44,       32'h48,       7,   0);
        add(0, 1, 0, X,                 1, 1, I48,          32'h48,       32'h4c,       8,   0);
        // redirect during stall to 0x44 drops the stalled word
        add(0, 0, 0, X,                 1, 1, I48,          32'h48,       32'h4c,       8,   0);
        add(0, 0, 1, 32'h44,            0, 0, X,            X,            32'h44,       8,   0);
        add(0, 1, 0, X,                 1, 1, I44,          32'h44,       32'h48,       8,   0);
        add(0, 1, 0, X,                 1, 1, I48,          32'h48,       32'h4c,       9,   0);
        // back-to-back redirects: last target wins
        add(0, 1, 1, 32'h40,            0, 0, X,            X,            32'h40,       10,  0);
        add(0, 1, 1, 32'h48,            0, 0, X,            X,            32'h48,       10,  0);
        add(0, 1, 0, X,                 1, 1, I48,          32'h48,       32'h4c,       10,  0);
        // mid-stream reset together with a redirect; redirect ignored in BOOT
        add(1, 1, 1, 32'h44,            1, 0, X,            X,            32'h40,       0,   0);
        add(0, 1, 1, 32'h80,            1, 0, X,            X,            32'h40,       0,   0);
        add(0, 1, 0, X,                 1, 1, I40,          32'h40,       32'h44,       0,   0);
        // PC wrap
        add(0, 1, 1, 32'hffff_fffc,     0, 0, X,            X,            32'hffff_fffc,1,   0);
        add(0, 1, 0, X,                 1, 1, 32'hdead_beef,32'hffff_fffc,32'h0,        1,   0);
        add(0, 1, 0, X,                 1, 1, 32'h0123_4567,32'h0,        32'h4,        2,   0);
`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned redirect freezes the unit until reset
        add(0, 1, 1, 32'h42,            0, 0, X,            X,            32'h42,       3,   1);
        add(0, 1, 0, X,                 0, 0, X,            X,            32'h42,       3,   1);
        add(0, 1, 1, 32'h40,            0, 0, X,            X,            32'h42,       3,   1);
`else
        // misaligned target used as given
        add(0, 1, 1, 32'h42,            0, 0, X,            X,            32'h42,       3,   0);
        add(0, 1, 0, X,                 1, 1, 32'h5a5a_0042,32'h42,       32'h46,       3,   0);
        add(0, 1, 1, 32'h40,            0, 0, X,            X,            32'h40,       4,   0);
`endif
        add(1, 1, 0, X,                 1, 0, X,            X,            32'h40,       0,   0);
        add(0, 1, 0, X,                 1, 0, X,            X,            32'h40,       0,   0);
        add(0, 1, 0, X,                 1, 1, I40,          32'h40,       32'h44,       0,   0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ready, vecs[i].br, vecs[i].target);
            check($sformatf("v%0d ir_valid", i), W'(ir_valid), W'(vecs[i].e_valid));
            check($sformatf("v%0d pcOut", i), pcOut, vecs[i].e_pcout);
            check($sformatf("v%0d fetch_count", i), fetch_count, vecs[i].e_count);
            check($sformatf("v%0d fetch_fault", i), W'(fetch_fault), W'(vecs[i].e_fault));
            if (vecs[i].chk_ir) begin
                check($sformatf("v%0d ir_inst", i), ir_inst, vecs[i].e_inst);
                check($sformatf("v%0d ir_pc", i), ir_pc, vecs[i].e_irpc);
                check($sformatf("v%0d ir_pcplus", i), ir_pcplus, vecs[i].e_irpc + 32'd4);
            end
        end

        // Hand sequence: first valid instruction exactly two edges after reset release.
        step(1, 1, 0, X);
        edges = 0;
        RESET = 1'b0;
        while (!ir_valid && edges < 10) begin
            @(posedge CLOCK_50);
            #1;
            edges++;
        end
        check("boot latency edges", W'(edges), 32'd2);
        check("boot first inst", ir_inst, I40);

        // Hand sequence: randomly placed redirect gives exactly one bubble.
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) step(0, 1, 0, X);
            step(0, 1, 1, 32'h44);
            check($sformatf("bubble%0d valid", k), W'(ir_valid), 32'd0);
            step(0, 1, 0, X);
            check($sformatf("bubble%0d valid after", k), W'(ir_valid), 32'd1);
            check($sformatf("bubble%0d ir_pc", k), ir_pc, 32'h44);
            check($sformatf("bubble%0d ir_inst", k), ir_inst, I44);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
